// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets and the timer type.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  typedef logic [63:0] mtime_t;

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk down to the mtime increment rate: one tick every Prescale cycles.
module clint_prescaler
  import clint_pkg::*;
#(
  parameter int unsigned Prescale = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Prescale - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // With Prescale == 1 the counter sits at 0 and every cycle is a tick.
  assign tick_o = (cnt_q == LastCnt);
  assign cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp timer and msip software interrupt.
// Single-cycle registered bus response; interrupt lines feed the CSR unit unmasked.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        timer_interrupt_o,
  output logic        software_interrupt_o
);

  logic        tick;
  mtime_t      mtime_q, mtime_d;
  mtime_t      mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_q, timer_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign unused_addr = ^addr_i[1:0];

  clint_prescaler #(
    .Prescale(PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .tick_o (tick)
  );

  always_comb begin
    rd_word    = '0;
    mtime_d    = mtime_q + mtime_t'(tick);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    unique case (addr_i[15:2])
      CLINT_MSIP[15:2]: begin
        rd_word = {31'b0, msip_q};
        if (req_i && we_i) msip_d = wdata_i[0];
      end
      CLINT_MTIMECMP_LO[15:2]: begin
        rd_word = mtimecmp_q[31:0];
        if (req_i && we_i) mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
      end
      CLINT_MTIMECMP_HI[15:2]: begin
        rd_word = mtimecmp_q[63:32];
        if (req_i && we_i) mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
      end
      // A write to either mtime half overrides that cycle's tick increment.
      CLINT_MTIME_LO[15:2]: begin
        rd_word = mtime_q[31:0];
        if (req_i && we_i) mtime_d = {mtime_q[63:32], wdata_i};
      end
      CLINT_MTIME_HI[15:2]: begin
        rd_word = mtime_q[63:32];
        if (req_i && we_i) mtime_d = {wdata_i, mtime_q[31:0]};
      end
      default: rd_word = '0;
    endcase

    rdata_d = (req_i && !we_i) ? rd_word : '0;
    timer_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      timer_q    <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      timer_q    <= timer_d;
      ack_q      <= req_i;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata_o              = rdata_q;
  assign ack_o                = ack_q;
  assign timer_interrupt_o    = timer_q;
  assign software_interrupt_o = msip_q;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: reads push expected data, a negedge monitor pops on ack.
module tb_clint;
  import clint_pkg::*;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack, timer_irq, sw_irq;

  logic        req4, we4;
  logic [15:0] addr4;
  logic [31:0] wdata4;
  logic [31:0] rdata4;
  logic        ack4, timer4, sw4;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_id = 0;
  bit   chk_en = 1'b0;
  bit   done4 = 1'b0;
  exp_t sb[$];
  exp_t e;

  // Reference model of the PRESCALE=1 instance.
  mtime_t m_mtime, m_cmp;
  logic   m_msip, exp_ack;

  always #5 clk = ~clk;

  clint #(.PRESCALE(1)) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .req_i               (req),
    .we_i                (we),
    .addr_i              (addr),
    .wdata_i             (wdata),
    .rdata_o             (rdata),
    .ack_o               (ack),
    .timer_interrupt_o   (timer_irq),
    .software_interrupt_o(sw_irq)
  );

  clint #(.PRESCALE(4)) dut4 (
    .clk_i               (clk),
    .reset_i             (reset),
    .req_i               (req4),
    .we_i                (we4),
    .addr_i              (addr4),
    .wdata_i             (wdata4),
    .rdata_o             (rdata4),
    .ack_o               (ack4),
    .timer_interrupt_o   (timer4),
    .software_interrupt_o(sw4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mtime <= '0;
      m_cmp   <= '1;
      m_msip  <= 1'b0;
      exp_ack <= 1'b0;
    end else begin
      exp_ack <= req;
      m_mtime <= m_mtime + 64'd1;
      if (req && we) begin
        case (addr[15:2])
          CLINT_MSIP[15:2]:        m_msip  <= wdata[0];
          CLINT_MTIMECMP_LO[15:2]: m_cmp   <= {m_cmp[63:32], wdata};
          CLINT_MTIMECMP_HI[15:2]: m_cmp   <= {wdata, m_cmp[31:0]};
          CLINT_MTIME_LO[15:2]:    m_mtime <= {m_mtime[63:32], wdata};
          CLINT_MTIME_HI[15:2]:    m_mtime <= {wdata, m_mtime[31:0]};
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", ack, exp_ack);
      check("timer_irq", timer_irq, m_mtime >= m_cmp);
      check("sw_irq", sw_irq, m_msip);
      if (ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.chk) check($sformatf("rdata#%0d", e.id), rdata, e.data);
        end
      end
    end
  end

  task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [31:0] exp_data);
    exp_t x;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    x.data = exp_data;
    x.chk  = !w;
    x.id   = n_id++;
    sb.push_back(x);
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // PRESCALE=4 instance: mtime during cycle k after reset is k/4.
  initial begin
    req4 = 1'b0; we4 = 1'b0; addr4 = CLINT_MTIME_LO; wdata4 = '0;
    @(negedge reset);
    repeat (2) @(posedge clk);
    #1 req4 = 1'b1;
    @(posedge clk);
    #1 req4 = 1'b0;
    #3;
    check("p4_ack0", ack4, 1);
    check("p4_mtime_c2", rdata4, 32'd0);
    repeat (39) @(posedge clk);
    #1 req4 = 1'b1;
    @(posedge clk);
    #1 req4 = 1'b0;
    #3;
    check("p4_ack1", ack4, 1);
    check("p4_mtime_c42", rdata4, 32'd10);
    check("p4_timer", timer4, 0);
    check("p4_sw", sw4, 0);
    done4 = 1'b1;
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // Cycle 0 onward: mtime equals the cycle index.
    bus(1'b0, CLINT_MTIME_LO, 0, 32'd0);
    bus(1'b0, CLINT_MTIME_LO, 0, 32'd1);
    bus(1'b0, CLINT_MTIMECMP_HI, 0, 32'hFFFF_FFFF);
    bus(1'b0, CLINT_MTIMECMP_LO, 0, 32'hFFFF_FFFF);
    bus(1'b1, CLINT_MTIMECMP_HI, 32'h0, 0);
    bus(1'b1, CLINT_MTIMECMP_LO, 32'd20, 0);
    idle(19);
    #3 check("timer_high_c25", timer_irq, 1);
    bus(1'b1, CLINT_MTIMECMP_LO, 32'd1000, 0);
    #3 check("timer_low_after_raise", timer_irq, 0);

    bus(1'b1, CLINT_MSIP, 32'hFFFF_FFFF, 0);
    #3 check("sw_set", sw_irq, 1);
    bus(1'b0, CLINT_MSIP, 0, 32'd1);
    bus(1'b1, CLINT_MSIP, 32'h0, 0);
    #3 check("sw_clear", sw_irq, 0);

    // Carry: the HI write lands on a tick cycle, so LO stays FFFF_FFFF one more cycle.
    bus(1'b1, CLINT_MTIME_LO, 32'hFFFF_FFFF, 0);
    bus(1'b1, CLINT_MTIME_HI, 32'h0, 0);
    bus(1'b0, CLINT_MTIME_LO, 0, 32'hFFFF_FFFF);
    bus(1'b0, CLINT_MTIME_LO, 0, 32'h0);
    bus(1'b0, CLINT_MTIME_HI, 0, 32'h1);
    #3 check("timer_after_carry", timer_irq, 1);

    bus(1'b0, 16'h1234, 0, 32'h0);
    bus(1'b1, CLINT_MSIP, 32'h1, 0);
    bus(1'b0, CLINT_MSIP, 0, 32'h1);
    idle(10);

    // Reset with a write in flight: ack dropped and write lost.
    reset = 1'b1;
    req = 1'b1; we = 1'b1; addr = CLINT_MSIP; wdata = 32'h1;
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0;
    #3 check("ack_dropped_by_reset", ack, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus(1'b0, CLINT_MTIMECMP_HI, 0, 32'hFFFF_FFFF);
    bus(1'b0, CLINT_MSIP, 0, 32'h0);
    idle(3);

    for (int i = 0; i < 100 && !done4; i++) idle(1);
    check("prescale4_done", done4, 1);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
